// File: rtl/index_decoder_pkg.sv
// Shared constants and FSM state type for the index decoder and its helpers.
package index_decoder_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int IDX_W_DEF = 3;
    localparam int CNT_W_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/index_decoder_popcount.sv
// Combinational ones-counter; also usable by the find-first-set encoder side.
module index_decoder_popcount
    import index_decoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/index_decoder.sv
// Accumulates a stream of bit indices into a set vector and emits one
// vector/popcount/error record per frame through a one-entry output register.
//
//   state | meaning
//   IDLE  | no beat accepted yet in the current frame, accumulator empty
//   ACCUM | at least one beat of the current frame has been accepted
module index_decoder
    import index_decoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_err
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             err_acc;

    logic             accept;
    logic             idx_ok;
    logic [WIDTH-1:0] beat_bit;
    logic [WIDTH-1:0] acc_cur;
    logic             err_cur;
    logic [WIDTH-1:0] load_vec;
    logic             load_err;
    logic [CNT_W-1:0] load_cnt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Extra MSB keeps the range check correct when 2^IDX_W == WIDTH.
    assign idx_ok   = {1'b0, in_idx} < (IDX_W + 1)'(WIDTH);
    assign beat_bit = idx_ok ? (WIDTH'(1) << in_idx) : '0;

    // A fresh frame starts from an empty accumulator regardless of leftovers.
    assign acc_cur  = (state == ACCUM) ? acc : '0;
    assign err_cur  = (state == ACCUM) ? err_acc : 1'b0;

    assign load_vec = acc_cur | beat_bit;
    assign load_err = err_cur | !idx_ok;

    index_decoder_popcount #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcount (
        .vec (load_vec),
        .cnt (load_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            err_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_cnt   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept && in_last) begin
                // A same-cycle drain and load leaves the new frame in place.
                state     <= IDLE;
                acc       <= '0;
                err_acc   <= 1'b0;
                out_valid <= 1'b1;
                out_vec   <= load_vec;
                out_cnt   <= load_cnt;
                out_err   <= load_err;
            end else begin
                if (accept) begin
                    state   <= ACCUM;
                    acc     <= load_vec;
                    err_acc <= load_err;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_index_decoder.sv
// Self-checking bench for index_decoder: directed scenarios plus randomized
// frames with random backpressure against a set-based reference model.
module tb_index_decoder;

    localparam int WIDTH = 6;
    localparam int IDX_W = 3;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vec;
    logic [CNT_W-1:0] out_cnt;
    logic             out_err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_vec_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];
    logic             exp_err_q[$];

    index_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_cnt   (out_cnt),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the frame is a set of in-range indices; count is its size.
    task automatic model_frame(input int idxs[$], output logic [WIDTH-1:0] vec,
                               output logic [CNT_W-1:0] cnt, output logic err);
        int n;
        vec = '0;
        err = 1'b0;
        n   = 0;
        foreach (idxs[i]) begin
            if (idxs[i] < WIDTH) vec[idxs[i]] = 1'b1;
            else err = 1'b1;
        end
        for (int b = 0; b < WIDTH; b++) if (vec[b]) n++;
        cnt = CNT_W'(n);
    endtask

    // Offers one beat for a single cycle; callers ensure in_ready is high.
    task automatic beat(input int idx, input logic last);
        in_valid = 1'b1;
        in_idx   = IDX_W'(idx);
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== '0 ||
            out_cnt !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b vec=%b cnt=%0d err=%b, want 1 0 000000 0 0",
                     in_ready, out_valid, out_vec, out_cnt, out_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        beat(3, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b001000 || out_cnt !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL single: valid=%b vec=%b cnt=%0d err=%b, want 1 001000 1 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
    endtask

    task automatic test_multi();
        beat(0, 1'b0);
        beat(5, 1'b0);
        beat(2, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_early: out_valid=%b mid-frame, want 0", out_valid);
        end
        beat(5, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b100101 || out_cnt !== 3'd3 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL multi: valid=%b vec=%b cnt=%0d err=%b, want 1 100101 3 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_one_cycle: out_valid=%b after drain, want 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        beat(7, 1'b0);
        beat(1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b000010 || out_cnt !== 3'd1 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL oor: valid=%b vec=%b cnt=%0d err=%b, want 1 000010 1 1",
                     out_valid, out_vec, out_cnt, out_err);
        end
        beat(4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b010000 || out_cnt !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_next: valid=%b vec=%b cnt=%0d err=%b, want 1 010000 1 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
    endtask

    task automatic test_backpressure();
        beat(3, 1'b0);
        out_ready = 1'b0;
        beat(1, 1'b1);
        in_valid = 1'b1;
        in_idx   = IDX_W'(2);
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 6'b001010 ||
                out_cnt !== 3'd2 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: in_ready=%b valid=%b vec=%b cnt=%0d err=%b, want 0 1 001010 2 0",
                         c, in_ready, out_valid, out_vec, out_cnt, out_err);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b000100 || out_cnt !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL release: valid=%b vec=%b cnt=%0d err=%b, want 1 000100 1 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < WIDTH; i++) beat(i, i == WIDTH - 1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b111111 || out_cnt !== 3'd6 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL full: valid=%b vec=%b cnt=%0d err=%b, want 1 111111 6 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
    endtask

    task automatic test_reset_mid();
        beat(1, 1'b0);
        beat(2, 1'b0);
        out_ready = 1'b0;
        beat(3, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_vec !== '0 || out_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: valid=%b vec=%b cnt=%0d in_ready=%b, want 0 000000 0 1",
                     out_valid, out_vec, out_cnt, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        beat(1, 1'b0);
        beat(2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        beat(4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 6'b010000 || out_cnt !== 3'd1 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b vec=%b cnt=%0d err=%b, want 1 010000 1 0",
                     out_valid, out_vec, out_cnt, out_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        localparam int NFRAMES = 60;
        int got = 0;
        exp_vec_q.delete();
        exp_cnt_q.delete();
        exp_err_q.delete();
        fork
            begin : driver
                for (int f = 0; f < NFRAMES; f++) begin
                    int idxs[$];
                    int len;
                    logic [WIDTH-1:0] ev;
                    logic [CNT_W-1:0] ec;
                    logic ee;
                    len = $urandom_range(5, 1);
                    idxs.delete();
                    for (int k = 0; k < len; k++) begin
                        idxs.push_back(($urandom_range(9, 0) == 0) ? $urandom_range(7, 6) : $urandom_range(5, 0));
                    end
                    model_frame(idxs, ev, ec, ee);
                    exp_vec_q.push_back(ev);
                    exp_cnt_q.push_back(ec);
                    exp_err_q.push_back(ee);
                    for (int k = 0; k < len; k++) begin
                        logic took;
                        int guard;
                        repeat ($urandom_range(3, 0) == 0 ? 1 : 0) begin
                            @(posedge clk);
                            #1;
                        end
                        in_valid = 1'b1;
                        in_idx   = IDX_W'(idxs[k]);
                        in_last  = (k == len - 1);
                        guard    = 0;
                        do begin
                            @(negedge clk);
                            took = in_ready;
                            @(posedge clk);
                            #1;
                            guard++;
                        end while (!took && guard < 200);
                        in_valid = 1'b0;
                        in_last  = 1'b0;
                    end
                end
            end
            begin : monitor
                logic held;
                logic [WIDTH-1:0] hv;
                logic [CNT_W-1:0] hc;
                logic he;
                held = 1'b0;
                hv = '0;
                hc = '0;
                he = 1'b0;
                for (int cyc = 0; cyc < 5000 && got < NFRAMES; cyc++) begin
                    @(negedge clk);
                    if (held) begin
                        checks++;
                        if (out_valid !== 1'b1 || out_vec !== hv || out_cnt !== hc || out_err !== he) begin
                            errors++;
                            $display("FAIL rand_hold: valid=%b vec=%b cnt=%0d err=%b, want 1 %b %0d %b",
                                     out_valid, out_vec, out_cnt, out_err, hv, hc, he);
                        end
                    end
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_vec_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra: unexpected frame vec=%b, want none", out_vec);
                        end else begin
                            if (out_vec !== exp_vec_q[0] || out_cnt !== exp_cnt_q[0] || out_err !== exp_err_q[0]) begin
                                errors++;
                                $display("FAIL rand_frame[%0d]: vec=%b cnt=%0d err=%b, want %b %0d %b",
                                         got, out_vec, out_cnt, out_err, exp_vec_q[0], exp_cnt_q[0], exp_err_q[0]);
                            end
                            void'(exp_vec_q.pop_front());
                            void'(exp_cnt_q.pop_front());
                            void'(exp_err_q.pop_front());
                        end
                        got++;
                    end
                    held = out_valid && !out_ready;
                    hv = out_vec;
                    hc = out_cnt;
                    he = out_err;
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(3, 0) != 0);
                end
            end
        join
        checks++;
        if (got != NFRAMES) begin
            errors++;
            $display("FAIL rand_timeout: frames received %0d, want %0d", got, NFRAMES);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_out_of_range();
        test_backpressure();
        test_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
